// File: rtl/sbus_pkg.sv
// rtl/sbus_pkg.sv - shared SBUS control layout, defaults and converter state encoding
package sbus_pkg;

  localparam int CTL_WIDTH       = 8;
  localparam int DEF_TDATA_WIDTH = 256;

  localparam int CTL_SOP      = 0;
  localparam int CTL_EOP      = 1;
  localparam int CTL_TRUNC    = 2;
  localparam int CTL_KEEP_ERR = 3;
  localparam int CTL_IDX_LSB  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IN_PKT = 2'd1,
    DROP   = 2'd2
  } sbus_state_t;

endpackage

// File: rtl/sbus_keep_check.sv
// rtl/sbus_keep_check.sv - combinational TKEEP check: full mask mid-packet, LSB-aligned non-empty mask on the last beat
module sbus_keep_check
  import sbus_pkg::*;
#(
  parameter int KEEP_WIDTH = DEF_TDATA_WIDTH / 8
) (
  input  logic [KEEP_WIDTH-1:0] i_keep,
  input  logic                  i_is_last,
  output logic                  o_err
);

  logic [KEEP_WIDTH-1:0] w_plus1;

  // A mask 2^n-1 has no bit in common with itself plus one.
  always_comb begin
    w_plus1 = i_keep + 1'b1;
    if (i_is_last) begin
      o_err = (i_keep == '0) || ((i_keep & w_plus1) != '0);
    end else begin
      o_err = (i_keep != '1);
    end
  end

endmodule

// File: rtl/axis_to_sbus.sv
// rtl/axis_to_sbus.sv - AXI4-Stream slave to valid-only SBUS master with per-beat control
// Optional A2SBUS_STATS_EN adds packet / truncation / keep-error counters.
module axis_to_sbus
  import sbus_pkg::*;
#(
  parameter int TDATA_WIDTH = DEF_TDATA_WIDTH,
  parameter int CTL_WIDTH   = 8,
  parameter int MAX_BEATS   = 64
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic                     S_AXIS_TVALID,
  input  logic [TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [TDATA_WIDTH/8-1:0] S_AXIS_TKEEP,
  input  logic                     S_AXIS_TLAST,
  output logic                     S_AXIS_TREADY,
  output logic                     M_SBUS_VALID,
  output logic [TDATA_WIDTH-1:0]   M_SBUS_TDATA,
  output logic [TDATA_WIDTH/8-1:0] M_SBUS_TKEEP,
  output logic [CTL_WIDTH-1:0]     M_SBUS_CTL
`ifdef A2SBUS_STATS_EN
  ,
  output logic [31:0]              STAT_PKT_CNT,
  output logic [15:0]              STAT_TRUNC_CNT,
  output logic [15:0]              STAT_KEEPERR_CNT
`endif
);

  localparam int KW   = TDATA_WIDTH / 8;
  localparam int IDXW = $clog2(MAX_BEATS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(MAX_BEATS - 1);

  sbus_state_t            r_state;
  logic [IDXW-1:0]        r_idx;
  logic                   r_tready;
  logic                   r_valid;
  logic [TDATA_WIDTH-1:0] r_tdata;
  logic [KW-1:0]          r_tkeep;
  logic [CTL_WIDTH-1:0]   r_ctl;

  logic                   w_accept;
  logic                   w_fwd;
  logic                   w_trunc;
  logic                   w_eop;
  logic                   w_keep_err;
  logic [3:0]             w_idx4;
  logic [CTL_WIDTH-1:0]   w_ctl;

  assign w_accept = S_AXIS_TVALID && r_tready;
  assign w_fwd    = w_accept && (r_state != DROP);
  // r_idx is 0 in IDLE and MAX_BEATS >= 2, so truncation can never hit a SOP beat.
  assign w_trunc  = (r_idx == LAST_IDX) && !S_AXIS_TLAST;
  assign w_eop    = S_AXIS_TLAST || w_trunc;
  assign w_idx4   = 4'(r_idx);

  sbus_keep_check #(.KEEP_WIDTH(KW)) u_keep_check (
    .i_keep    (S_AXIS_TKEEP),
    .i_is_last (S_AXIS_TLAST),
    .o_err     (w_keep_err)
  );

  always_comb begin
    w_ctl                     = '0;
    w_ctl[CTL_SOP]            = (r_state == IDLE);
    w_ctl[CTL_EOP]            = w_eop;
    w_ctl[CTL_TRUNC]          = w_trunc;
    w_ctl[CTL_KEEP_ERR]       = w_keep_err;
    w_ctl[CTL_IDX_LSB +: 4]   = w_idx4;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_tready <= 1'b0;
      r_valid  <= 1'b0;
      r_tdata  <= '0;
      r_tkeep  <= '0;
      r_ctl    <= '0;
    end else begin
      r_tready <= 1'b1;
      r_valid  <= w_fwd;
      r_tdata  <= w_fwd ? S_AXIS_TDATA : '0;
      r_tkeep  <= w_fwd ? S_AXIS_TKEEP : '0;
      r_ctl    <= w_fwd ? w_ctl : '0;
      if (w_accept) begin
        case (r_state)
          IDLE, IN_PKT: begin
            if (S_AXIS_TLAST) begin
              r_state <= IDLE;
              r_idx   <= '0;
            end else if (w_trunc) begin
              r_state <= DROP;
              r_idx   <= '0;
            end else begin
              r_state <= IN_PKT;
              r_idx   <= r_idx + 1'b1;
            end
          end
          DROP: begin
            if (S_AXIS_TLAST) r_state <= IDLE;
          end
          default: begin
            r_state <= IDLE;
            r_idx   <= '0;
          end
        endcase
      end
    end
  end

  assign S_AXIS_TREADY = r_tready;
  assign M_SBUS_VALID  = r_valid;
  assign M_SBUS_TDATA  = r_tdata;
  assign M_SBUS_TKEEP  = r_tkeep;
  assign M_SBUS_CTL    = r_ctl;

`ifdef A2SBUS_STATS_EN
  logic [31:0] r_pkt_cnt;
  logic [15:0] r_trunc_cnt;
  logic [15:0] r_keeperr_cnt;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_pkt_cnt     <= '0;
      r_trunc_cnt   <= '0;
      r_keeperr_cnt <= '0;
    end else if (w_fwd) begin
      if (w_eop)      r_pkt_cnt     <= r_pkt_cnt + 1'b1;
      if (w_trunc)    r_trunc_cnt   <= r_trunc_cnt + 1'b1;
      if (w_keep_err) r_keeperr_cnt <= r_keeperr_cnt + 1'b1;
    end
  end

  assign STAT_PKT_CNT     = r_pkt_cnt;
  assign STAT_TRUNC_CNT   = r_trunc_cnt;
  assign STAT_KEEPERR_CNT = r_keeperr_cnt;
`endif

endmodule

// File: tb/tb_axis_to_sbus.sv
// tb/tb_axis_to_sbus.sv - directed and randomized bench for axis_to_sbus against a packet-level model
module tb_axis_to_sbus;

  localparam int DW  = 256;
  localparam int KW  = DW / 8;
  localparam int MAX = 4;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic          S_AXIS_TVALID = 1'b0;
  logic [DW-1:0] S_AXIS_TDATA = '0;
  logic [KW-1:0] S_AXIS_TKEEP = '0;
  logic          S_AXIS_TLAST = 1'b0;
  logic          S_AXIS_TREADY;
  logic          M_SBUS_VALID;
  logic [DW-1:0] M_SBUS_TDATA;
  logic [KW-1:0] M_SBUS_TKEEP;
  logic [7:0]    M_SBUS_CTL;
`ifdef A2SBUS_STATS_EN
  logic [31:0]   STAT_PKT_CNT;
  logic [15:0]   STAT_TRUNC_CNT;
  logic [15:0]   STAT_KEEPERR_CNT;
`endif

  axis_to_sbus #(.TDATA_WIDTH(DW), .CTL_WIDTH(8), .MAX_BEATS(MAX)) dut (
    .ACLK             (ACLK),
    .ARESETN          (ARESETN),
    .S_AXIS_TVALID    (S_AXIS_TVALID),
    .S_AXIS_TDATA     (S_AXIS_TDATA),
    .S_AXIS_TKEEP     (S_AXIS_TKEEP),
    .S_AXIS_TLAST     (S_AXIS_TLAST),
    .S_AXIS_TREADY    (S_AXIS_TREADY),
    .M_SBUS_VALID     (M_SBUS_VALID),
    .M_SBUS_TDATA     (M_SBUS_TDATA),
    .M_SBUS_TKEEP     (M_SBUS_TKEEP),
    .M_SBUS_CTL       (M_SBUS_CTL)
`ifdef A2SBUS_STATS_EN
    ,
    .STAT_PKT_CNT     (STAT_PKT_CNT),
    .STAT_TRUNC_CNT   (STAT_TRUNC_CNT),
    .STAT_KEEPERR_CNT (STAT_KEEPERR_CNT)
`endif
  );

  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad   = 0;

  // Packet-level model: position inside the current packet, dropping flag, ready.
  bit m_ready = 0;
  bit m_drop  = 0;
  int m_pos   = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit keep_bad(input logic [KW-1:0] k, input bit last);
    logic [63:0] kz;
    if (!last) return k != {KW{1'b1}};
    kz = {32'b0, k};
    for (int n = 1; n <= KW; n++)
      if (kz == ((64'd1 << n) - 64'd1)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Applies one cycle of input, advances the model, checks outputs #1 after the edge.
  task automatic step(input bit rn, input bit v, input logic [DW-1:0] d,
                      input logic [KW-1:0] k, input bit l, input int want = -1);
    bit         ev;
    logic [7:0] ectl;
    bit         trunc;
    ev = 0;
    ectl = 8'h00;
    ARESETN = rn; S_AXIS_TVALID = v; S_AXIS_TDATA = d; S_AXIS_TKEEP = k; S_AXIS_TLAST = l;
    if (!rn) begin
      m_ready = 0; m_drop = 0; m_pos = 0;
    end else begin
      if (v && m_ready) begin
        if (m_drop) begin
          if (l) m_drop = 0;
        end else begin
          trunc = (m_pos == MAX - 1) && !l;
          ev = 1;
          ectl = {4'(m_pos % 16), keep_bad(k, l), trunc, l | trunc, m_pos == 0};
          if (l) m_pos = 0;
          else if (trunc) begin m_pos = 0; m_drop = 1; end
          else m_pos++;
        end
      end
      m_ready = 1;
    end
    @(posedge ACLK);
    #1;
    chk("tready", DW'(S_AXIS_TREADY), DW'(m_ready));
    chk("valid",  DW'(M_SBUS_VALID),  DW'(ev));
    chk("tdata",  M_SBUS_TDATA,       ev ? d : '0);
    chk("tkeep",  DW'(M_SBUS_TKEEP),  ev ? DW'(k) : '0);
    chk("ctl",    DW'(M_SBUS_CTL),    DW'(ectl));
    if (want >= 0) chk("ctl_plan", DW'(M_SBUS_CTL), DW'(want));
  endtask

  localparam logic [KW-1:0] ONES = '1;

  initial begin
    // Reset hold, then TREADY rises one cycle after release.
    for (int i = 0; i < 12; i++) step(0, 1, rand_data(), ONES, 0, 0);
    step(1, 1, rand_data(), ONES, 1, 0);
    step(1, 0, '0, '0, 0, 0);

    // Three-beat packet with partial last keep.
    step(1, 1, rand_data(), ONES, 0, 8'h01);
    step(1, 1, rand_data(), ONES, 0, 8'h10);
    step(1, 1, rand_data(), 32'h0000FFFF, 1, 8'h22);

    // Single-beat packets: good mask and empty mask.
    step(1, 1, rand_data(), 32'h000000FF, 1, 8'h03);
    step(1, 1, rand_data(), 32'h00000000, 1, 8'h0B);

    // Non-full keep mid-packet is flagged but forwarded.
    step(1, 1, rand_data(), 32'hFFFFFFFE, 0, 8'h09);
    step(1, 1, rand_data(), 32'h00FFFF00, 1, 8'h1A);

    // Truncation of a 6-beat packet at MAX=4.
    step(1, 1, rand_data(), ONES, 0, 8'h01);
    step(1, 1, rand_data(), ONES, 0, 8'h10);
    step(1, 1, rand_data(), ONES, 0, 8'h20);
    step(1, 1, rand_data(), ONES, 0, 8'h36);
    step(1, 1, rand_data(), ONES, 0, 8'h00);
    step(1, 1, rand_data(), ONES, 1, 8'h00);
    step(1, 1, rand_data(), ONES, 0, 8'h01);
    step(1, 1, rand_data(), ONES, 1, 8'h12);

    // Reset mid-packet, then a TVALID gap inside the next packet.
    step(1, 1, rand_data(), ONES, 0, 8'h01);
    step(1, 1, rand_data(), ONES, 0, 8'h10);
    step(0, 1, rand_data(), ONES, 0, 8'h00);
    step(1, 0, '0, '0, 0, 8'h00);
    step(1, 1, rand_data(), ONES, 0, 8'h01);
    step(1, 0, rand_data(), ONES, 0, 8'h00);
    step(1, 1, rand_data(), ONES, 0, 8'h10);
    step(1, 1, rand_data(), 32'h0000000F, 1, 8'h22);

    // Randomized packets, gaps, masks and occasional resets.
    for (int p = 0; p < 60; p++) begin
      int len;
      len = $urandom_range(1, 7);
      for (int b = 0; b < len; b++) begin
        bit            last;
        logic [KW-1:0] k;
        last = (b == len - 1);
        case ($urandom_range(0, 3))
          0:       k = KW'($urandom);
          1:       k = last ? KW'((64'd1 << $urandom_range(0, KW)) - 64'd1) : ONES;
          default: k = ONES;
        endcase
        while ($urandom_range(0, 3) == 0) step(1, 0, rand_data(), k, $urandom_range(0, 1));
        if ($urandom_range(0, 40) == 0) step(0, 1, rand_data(), k, last);
        step(1, 1, rand_data(), k, last);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
